// File: rtl/opll_bus_pkg.sv
// Shared types and bus addresses for the OPLL bus initiator.
package opll_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    A_WAIT,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    D_WAIT
  } state_t;

  localparam logic [7:0]  IO_ADDR  = 8'h7C;
  localparam logic [15:0] MIO_ADDR = 16'h7FF4;

  // "reg" is a keyword, so the register-number field is regnum
  typedef struct packed {
    logic [7:0] regnum;
    logic [7:0] data;
  } opll_req_t;

endpackage

// File: rtl/opll_req_fifo.sv
// Small first-word-fall-through request FIFO; slot 0 is always the head, so all outputs come from registers.
module opll_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             pop_ok, push_ok;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)
      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok)
      count_d = count_q - 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
      if (pop_ok) begin
        slot_d[i] = slot_q[(i < DEPTH - 1) ? i + 1 : i];
        if (push_ok && int'(count_q) == i + 1)
          slot_d[i] = data_i;
      end else if (push_ok && int'(count_q) == i) begin
        slot_d[i] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++)
        slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      for (int i = 0; i < DEPTH; i++)
        slot_q[i] <= slot_d[i];
    end
  end

  assign data_o  = slot_q[0];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/opll_bus_master.sv
// OPLL register-write initiator: each (reg,data) request becomes an address write then a data write,
// each followed by a CLK_EN-timed wait. Define OPLL_BUS_MASTER_FIFO_EN for a 4-deep request FIFO.
module opll_bus_master
  import opll_bus_pkg::*;
#(
  parameter int MEM_MAPPED    = 0,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int ADDR_WAIT     = 12,
  parameter int DATA_WAIT     = 84
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CLK_EN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [7:0]  REQ_REG,
  input  logic [7:0]  REQ_DATA,
  output logic        BUSY,
  output logic [15:0] ADDR,
  output logic [7:0]  DOUT,
  output logic        WR_n,
  output logic        IORQ_n,
  output logic        MERQ_n,
  output logic        SLTSL_n
);

  localparam int          PW        = 16;
  localparam logic [15:0] BASE_ADDR = (MEM_MAPPED != 0) ? MIO_ADDR : {8'h00, IO_ADDR};

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_phase
    $error("opll_bus_master: SETUP/STROBE/HOLD_CYCLES must be >= 1");
  end
  if (ADDR_WAIT < 1 || ADDR_WAIT > 127 || DATA_WAIT < 1 || DATA_WAIT > 127) begin : g_bad_wait
    $error("opll_bus_master: ADDR_WAIT/DATA_WAIT must be 1..127");
  end

  state_t          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [6:0]      wait_q, wait_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      data_q, data_d;
  logic            run_q;
  logic            wr_q, iorq_q, merq_q, sltsl_q;
  logic            strobe_d;
  logic            last_tick, can_take, head_valid, pop;
  opll_req_t       head;

  assign last_tick = (state_q == D_WAIT) && CLK_EN && (wait_q == 7'd1);
  assign can_take  = run_q && ((state_q == IDLE) || last_tick);
  assign pop       = can_take && head_valid;

`ifdef OPLL_BUS_MASTER_FIFO_EN
  logic      fifo_full, fifo_empty;
  opll_req_t fifo_head;

  opll_req_fifo #(
    .DEPTH (4),
    .WIDTH ($bits(opll_req_t))
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_n),
    .push_i  (REQ_VALID && REQ_READY),
    .data_i  ({REQ_REG, REQ_DATA}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_valid = !fifo_empty;
  assign head       = fifo_head;
  assign REQ_READY  = run_q && (!fifo_full || pop);
  assign BUSY       = (state_q != IDLE) || !fifo_empty;
`else
  // Ready follows CLK_EN combinationally on the final wait tick so the next request issues with no bubble
  assign head_valid = REQ_VALID;
  assign head       = '{regnum: REQ_REG, data: REQ_DATA};
  assign REQ_READY  = can_take;
  assign BUSY       = (state_q != IDLE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    data_d  = data_q;
    case (state_q)
      A_SETUP, D_SETUP: begin
        if (cnt_q == '0) begin
          state_d = (state_q == A_SETUP) ? A_STROBE : D_STROBE;
          cnt_d   = PW'(STROBE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      A_STROBE, D_STROBE: begin
        if (cnt_q == '0) begin
          state_d = (state_q == A_STROBE) ? A_HOLD : D_HOLD;
          cnt_d   = PW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      A_HOLD, D_HOLD: begin
        if (cnt_q == '0) begin
          state_d = (state_q == A_HOLD) ? A_WAIT : D_WAIT;
          wait_d  = (state_q == A_HOLD) ? 7'(ADDR_WAIT) : 7'(DATA_WAIT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      A_WAIT: begin
        if (CLK_EN) begin
          if (wait_q == 7'd1) begin
            state_d = D_SETUP;
            cnt_d   = PW'(SETUP_CYCLES - 1);
            addr_d  = BASE_ADDR + 16'd1;
            dout_d  = data_q;
          end else begin
            wait_d = wait_q - 7'd1;
          end
        end
      end
      D_WAIT: begin
        if (CLK_EN) begin
          if (wait_q == 7'd1)
            state_d = IDLE;
          else
            wait_d = wait_q - 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d = A_SETUP;
      cnt_d   = PW'(SETUP_CYCLES - 1);
      addr_d  = BASE_ADDR;
      dout_d  = head.regnum;
      data_d  = head.data;
    end
  end

  assign strobe_d = (state_d == A_STROBE) || (state_d == D_STROBE);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      data_q  <= '0;
      run_q   <= 1'b0;
      wr_q    <= 1'b1;
      iorq_q  <= 1'b1;
      merq_q  <= 1'b1;
      sltsl_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      data_q  <= data_d;
      run_q   <= 1'b1;
      wr_q    <= !strobe_d;
      iorq_q  <= !(strobe_d && (MEM_MAPPED == 0));
      merq_q  <= !(strobe_d && (MEM_MAPPED != 0));
      sltsl_q <= !(strobe_d && (MEM_MAPPED != 0));
    end
  end

  assign ADDR    = addr_q;
  assign DOUT    = dout_q;
  assign WR_n    = wr_q;
  assign IORQ_n  = iorq_q;
  assign MERQ_n  = merq_q;
  assign SLTSL_n = sltsl_q;

endmodule

// File: tb/tb_opll_bus_master.sv
// Directed bench for opll_bus_master: one I/O-mode and one memory-mapped instance share clock, reset and CLK_EN.
`timescale 1ns/1ps
module tb_opll_bus_master;

  localparam int SETUP  = 2;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int AW     = 12;
  localparam int DW     = 84;
  localparam int LOGN   = 32768;
`ifdef OPLL_BUS_MASTER_FIFO_EN
  localparam int POP_LAT = 1;
`else
  localparam int POP_LAT = 0;
`endif

  typedef struct {
    int          fall;
    int          rise;
    logic [15:0] addr;
    logic [7:0]  dout;
  } strobe_rec_t;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b1;
  logic        CLK_EN = 1'b0;
  logic        io_valid = 1'b0, mem_valid = 1'b0;
  logic [7:0]  req_reg = 8'h00, req_data = 8'h00;
  logic        io_ready, io_busy, io_wr_n, io_iorq_n, io_merq_n, io_sltsl_n;
  logic        mem_ready, mem_busy, mem_wr_n, mem_iorq_n, mem_merq_n, mem_sltsl_n;
  logic [15:0] io_addr, mem_addr;
  logic [7:0]  io_dout, mem_dout;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          en_run = 1'b1;
  bit          en_log [LOGN];
  int          edge_n = 0;
  strobe_rec_t io_recs[$], mem_recs[$];
  int          io_acc[$], mem_acc[$];
  int          io_busy_fall = -1, mem_busy_fall = -1;
  int          stab_bad = 0, io_line_bad = 0, mem_line_bad = 0;
  int          io_fall, mem_fall;
  logic [15:0] io_a, mem_a, io_prev_addr = '0, mem_prev_addr = '0;
  logic [7:0]  io_d, mem_d;
  logic        io_prev_wr = 1'b1, mem_prev_wr = 1'b1, io_prev_busy = 1'b0, mem_prev_busy = 1'b0;

  always #5 CLK = ~CLK;

  opll_bus_master #(
    .MEM_MAPPED(0), .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD),
    .ADDR_WAIT(AW), .DATA_WAIT(DW)
  ) u_io (
    .CLK(CLK), .RESET_n(RESET_n), .CLK_EN(CLK_EN), .REQ_VALID(io_valid), .REQ_READY(io_ready),
    .REQ_REG(req_reg), .REQ_DATA(req_data), .BUSY(io_busy), .ADDR(io_addr), .DOUT(io_dout),
    .WR_n(io_wr_n), .IORQ_n(io_iorq_n), .MERQ_n(io_merq_n), .SLTSL_n(io_sltsl_n)
  );

  opll_bus_master #(
    .MEM_MAPPED(1), .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD),
    .ADDR_WAIT(AW), .DATA_WAIT(DW)
  ) u_mem (
    .CLK(CLK), .RESET_n(RESET_n), .CLK_EN(CLK_EN), .REQ_VALID(mem_valid), .REQ_READY(mem_ready),
    .REQ_REG(req_reg), .REQ_DATA(req_data), .BUSY(mem_busy), .ADDR(mem_addr), .DOUT(mem_dout),
    .WR_n(mem_wr_n), .IORQ_n(mem_iorq_n), .MERQ_n(mem_merq_n), .SLTSL_n(mem_sltsl_n)
  );

  // CLK_EN: one pulse every third clock while en_run is set
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge CLK);
      #2;
      CLK_EN = en_run && (div == 2);
      div = (div == 2) ? 0 : div + 1;
    end
  end

  // At each negedge: inputs are what the next posedge (edge_n) will see; outputs reflect edge_n-1.
  always @(negedge CLK) begin
    if (edge_n < LOGN) en_log[edge_n] <= CLK_EN;
    if (io_valid && io_ready) io_acc.push_back(edge_n);
    if (mem_valid && mem_ready) mem_acc.push_back(edge_n);

    if (!io_wr_n && io_prev_wr) begin
      io_fall <= edge_n - 1; io_a <= io_addr; io_d <= io_dout;
      if (io_addr !== io_prev_addr) stab_bad <= stab_bad + 1;
    end
    if (!io_prev_wr && (io_addr !== io_a || io_dout !== io_d) && RESET_n) stab_bad <= stab_bad + 1;
    if (io_wr_n && !io_prev_wr) io_recs.push_back('{io_fall, edge_n - 1, io_a, io_d});
    if (!io_busy && io_prev_busy) io_busy_fall <= edge_n - 1;
    if (io_iorq_n !== io_wr_n || io_merq_n !== 1'b1 || io_sltsl_n !== 1'b1) io_line_bad <= io_line_bad + 1;

    if (!mem_wr_n && mem_prev_wr) begin
      mem_fall <= edge_n - 1; mem_a <= mem_addr; mem_d <= mem_dout;
      if (mem_addr !== mem_prev_addr) stab_bad <= stab_bad + 1;
    end
    if (!mem_prev_wr && (mem_addr !== mem_a || mem_dout !== mem_d) && RESET_n) stab_bad <= stab_bad + 1;
    if (mem_wr_n && !mem_prev_wr) mem_recs.push_back('{mem_fall, edge_n - 1, mem_a, mem_d});
    if (!mem_busy && mem_prev_busy) mem_busy_fall <= edge_n - 1;
    if (mem_merq_n !== mem_wr_n || mem_sltsl_n !== mem_wr_n || mem_iorq_n !== 1'b1) mem_line_bad <= mem_line_bad + 1;

    io_prev_wr <= io_wr_n;   mem_prev_wr <= mem_wr_n;
    io_prev_busy <= io_busy; mem_prev_busy <= mem_busy;
    io_prev_addr <= io_addr; mem_prev_addr <= mem_addr;
    edge_n <= edge_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge index of the n-th CLK_EN pulse seen strictly after edge e
  function automatic int nth_en(input int e, input int n);
    int left;
    left = n;
    for (int k = e + 1; k < LOGN; k++) begin
      if (en_log[k]) begin
        left--;
        if (left == 0) return k;
      end
    end
    return -1;
  endfunction

  // a/b: address and data strobes of one transaction whose A_SETUP was entered at edge start
  task automatic chk_txn(input string tag, input strobe_rec_t a, input strobe_rec_t b,
                         input logic [15:0] base, input logic [7:0] r, input logic [7:0] d,
                         input int start, output int done);
    chk({tag, ".a_addr"}, 32'(a.addr), 32'(base));
    chk({tag, ".a_dout"}, 32'(a.dout), 32'(r));
    chk({tag, ".a_fall"}, a.fall, start + SETUP);
    chk({tag, ".a_len"},  a.rise - a.fall, STROBE);
    chk({tag, ".d_addr"}, 32'(b.addr), 32'(base) + 1);
    chk({tag, ".d_dout"}, 32'(b.dout), 32'(d));
    chk({tag, ".d_fall"}, b.fall, nth_en(a.rise + HOLD, AW) + SETUP);
    chk({tag, ".d_len"},  b.rise - b.fall, STROBE);
    done = nth_en(b.rise + HOLD, DW);
  endtask

  task automatic send(input bit to_mem, input logic [7:0] r, input logic [7:0] d);
    int t;
    req_reg = r; req_data = d;
    if (to_mem) mem_valid = 1'b1; else io_valid = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!(to_mem ? mem_ready : io_ready) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("accept_in_time", 32'(t < 3000), 32'd1);
    @(posedge CLK); #2;
    io_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit to_mem);
    int t;
    t = 0;
    @(negedge CLK);
    while ((to_mem ? mem_busy : io_busy) && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    chk("idle_in_time", 32'(t < 5000), 32'd1);
    @(posedge CLK); #2;
  endtask

  task automatic clear_logs();
    io_recs.delete(); mem_recs.delete(); io_acc.delete(); mem_acc.delete();
  endtask

  initial begin
    int done0, done1, done2, t;

    // Reset values
    #1 RESET_n = 1'b0;
    #2;
    chk("rst.wr_n", 32'(io_wr_n), 32'd1);
    chk("rst.iorq_n", 32'(io_iorq_n), 32'd1);
    chk("rst.merq_n", 32'(mem_merq_n), 32'd1);
    chk("rst.sltsl_n", 32'(mem_sltsl_n), 32'd1);
    chk("rst.addr", 32'(io_addr), 32'h0);
    chk("rst.dout", 32'(io_dout), 32'h0);
    chk("rst.ready", 32'(io_ready), 32'd0);
    chk("rst.busy", 32'(io_busy), 32'd0);
    repeat (3) @(posedge CLK);
    #2 RESET_n = 1'b1;
    @(posedge CLK); #2;
    chk("post_rst.ready", 32'(io_ready), 32'd1);
    chk("post_rst.busy", 32'(io_busy), 32'd0);

    // T1: I/O mode single request
    clear_logs();
    send(1'b0, 8'h10, 8'h55);
    wait_idle(1'b0);
    chk("t1.accepts", io_acc.size(), 1);
    chk("t1.strobes", io_recs.size(), 2);
    if (io_recs.size() >= 2 && io_acc.size() >= 1) begin
      chk_txn("t1", io_recs[0], io_recs[1], 16'h007C, 8'h10, 8'h55, io_acc[0] + POP_LAT, done0);
      chk("t1.busy_fall", io_busy_fall, done0);
    end

    // T2: memory-mapped request
    clear_logs();
    send(1'b1, 8'h30, 8'hA3);
    wait_idle(1'b1);
    chk("t2.strobes", mem_recs.size(), 2);
    if (mem_recs.size() >= 2 && mem_acc.size() >= 1) begin
      chk_txn("t2", mem_recs[0], mem_recs[1], 16'h7FF4, 8'h30, 8'hA3, mem_acc[0] + POP_LAT, done0);
      chk("t2.busy_fall", mem_busy_fall, done0);
    end
    chk("t2.io_idle", io_recs.size(), 0);

`ifdef OPLL_BUS_MASTER_FIFO_EN
    // T3: three requests on consecutive cycles into the FIFO
    clear_logs();
    io_valid = 1'b1;
    req_reg = 8'h20; req_data = 8'h11;
    @(negedge CLK); chk("t3.ready0", 32'(io_ready), 32'd1);
    @(posedge CLK); #2 req_reg = 8'h21; req_data = 8'h22;
    @(negedge CLK); chk("t3.ready1", 32'(io_ready), 32'd1);
    @(posedge CLK); #2 req_reg = 8'h22; req_data = 8'h33;
    @(negedge CLK); chk("t3.ready2", 32'(io_ready), 32'd1);
    @(posedge CLK); #2 io_valid = 1'b0;
    wait_idle(1'b0);
    chk("t3.accepts", io_acc.size(), 3);
    chk("t3.strobes", io_recs.size(), 6);
    if (io_recs.size() >= 6 && io_acc.size() >= 1) begin
      chk_txn("t3.0", io_recs[0], io_recs[1], 16'h007C, 8'h20, 8'h11, io_acc[0] + 1, done0);
      chk_txn("t3.1", io_recs[2], io_recs[3], 16'h007C, 8'h21, 8'h22, done0, done1);
      chk_txn("t3.2", io_recs[4], io_recs[5], 16'h007C, 8'h22, 8'h33, done1, done2);
      chk("t3.busy_fall", io_busy_fall, done2);
    end
`else
    // T4: VALID held across two transactions; one accept each
    clear_logs();
    io_valid = 1'b1;
    req_reg = 8'h0E; req_data = 8'h20;
    for (int n = 0; n < 2; n++) begin
      t = 0;
      @(negedge CLK);
      while (!io_ready && t < 3000) begin
        @(negedge CLK);
        t++;
      end
      chk("t4.accept_in_time", 32'(t < 3000), 32'd1);
      @(posedge CLK); #2;
      req_reg = 8'h0F; req_data = 8'h3F;
    end
    io_valid = 1'b0;
    wait_idle(1'b0);
    chk("t4.accepts", io_acc.size(), 2);
    chk("t4.strobes", io_recs.size(), 4);
    if (io_recs.size() >= 4 && io_acc.size() >= 2) begin
      chk_txn("t4.0", io_recs[0], io_recs[1], 16'h007C, 8'h0E, 8'h20, io_acc[0], done0);
      chk("t4.second_accept", io_acc[1], done0);
      chk_txn("t4.1", io_recs[2], io_recs[3], 16'h007C, 8'h0F, 8'h3F, io_acc[1], done1);
      chk("t4.busy_fall", io_busy_fall, done1);
    end
`endif

    // T5: reset during the data strobe, then a clean transaction
    clear_logs();
    send(1'b0, 8'h44, 8'h66);
    t = 0;
    @(negedge CLK);
    while (!(io_recs.size() == 1 && !io_wr_n) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("t5.reached_d_strobe", 32'(t < 3000), 32'd1);
    #2 RESET_n = 1'b0;
    #1;
    chk("t5.wr_n", 32'(io_wr_n), 32'd1);
    chk("t5.iorq_n", 32'(io_iorq_n), 32'd1);
    chk("t5.busy", 32'(io_busy), 32'd0);
    chk("t5.ready", 32'(io_ready), 32'd0);
    chk("t5.addr", 32'(io_addr), 32'h0);
    repeat (2) @(posedge CLK);
    #2 RESET_n = 1'b1;
    repeat (2) @(posedge CLK);
    #2 clear_logs();
    send(1'b0, 8'h21, 8'h9C);
    wait_idle(1'b0);
    chk("t5.strobes", io_recs.size(), 2);
    if (io_recs.size() >= 2 && io_acc.size() >= 1) begin
      chk_txn("t5", io_recs[0], io_recs[1], 16'h007C, 8'h21, 8'h9C, io_acc[0] + POP_LAT, done0);
      chk("t5.busy_fall", io_busy_fall, done0);
    end

    // T6: CLK_EN stopped for 500 clocks inside A_WAIT
    clear_logs();
    send(1'b0, 8'h07, 8'h0F);
    t = 0;
    @(negedge CLK);
    while (io_recs.size() < 1 && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("t6.addr_write", 32'(t < 3000), 32'd1);
    repeat (3) @(posedge CLK);
    #2 en_run = 1'b0;
    repeat (500) @(posedge CLK);
    #2;
    chk("t6.no_data_write", io_recs.size(), 1);
    chk("t6.still_busy", 32'(io_busy), 32'd1);
    en_run = 1'b1;
    wait_idle(1'b0);
    chk("t6.strobes", io_recs.size(), 2);
    if (io_recs.size() >= 2 && io_acc.size() >= 1) begin
      chk_txn("t6", io_recs[0], io_recs[1], 16'h007C, 8'h07, 8'h0F, io_acc[0] + POP_LAT, done0);
      chk("t6.busy_fall", io_busy_fall, done0);
    end

    // Bus-level invariants over the whole run
    chk("addr_dout_stable", stab_bad, 0);
    chk("io_lines", io_line_bad, 0);
    chk("mem_lines", mem_line_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
